// File: rtl/trace_checker_pkg.sv
// Shared types for the retire-trace checker: FSM states, failure causes and
// the golden record layout held in the two-entry buffer.
package trace_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_RUN  = 3'd2,
        ST_PASS = 3'd3,
        ST_FAIL = 3'd4
    } state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_PC       = 2'd1;
    localparam logic [1:0] CAUSE_INST     = 2'd2;
    localparam logic [1:0] CAUSE_UNDERRUN = 2'd3;

    localparam int REC_W = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo2.sv
// Two-entry FIFO for golden trace records; push and pop may coincide,
// and a push into a full FIFO is accepted only when a pop frees a slot.
module trace_fifo2
    import trace_checker_pkg::*;
#(
    parameter int W = REC_W
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         push_ok;
    logic         pop_ok;

    always_comb begin
        pop_ok  = pop && (count_q != 2'd0);
        push_ok = push && ((count_q != 2'd2) || pop_ok);
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk_in) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/trace_checker.sv
// Compares each retiring CPU instruction with a prefetched golden record and
// latches the first mismatch or underrun, or PASS after TRACE_LEN matches.
module trace_checker
    import trace_checker_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int TRACE_LEN = 1024
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cpu_valid,
    input  logic [31:0]       cpu_pc,
    input  logic [31:0]       cpu_inst,
    output logic              cpu_hold,
    output logic              gold_req,
    output logic [ADDR_W-1:0] gold_addr,
    input  logic              gold_ack,
    input  logic [31:0]       gold_pc,
    input  logic [31:0]       gold_inst,
    output logic              chk_done,
    output logic              chk_pass,
    output logic              chk_fail,
    output logic [1:0]        fail_cause,
    output logic [ADDR_W-1:0] fail_index,
    output logic [31:0]       fail_pc,
    output logic [31:0]       fail_inst,
    output logic [ADDR_W:0]   match_count
);

    localparam logic [ADDR_W:0] LEN = (ADDR_W+1)'(TRACE_LEN);

    state_e            state_q, state_d;
    logic              hold_q;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   fetch_q;
    logic [ADDR_W:0]   match_q;
    logic              done_q, pass_q, fail_q;
    logic [1:0]        cause_q, cause_d;
    logic [ADDR_W-1:0] fidx_q;
    logic [31:0]       fpc_q, finst_q;

    logic              active;
    logic              ack_ok;
    logic              pop;
    logic              hit;
    logic              raise;
    logic [1:0]        fifo_count;
    trace_rec_t        fifo_head;
    trace_rec_t        push_rec;

    always_comb begin
        push_rec      = '0;
        push_rec.pc   = gold_pc;
        push_rec.inst = gold_inst;
    end

    trace_fifo2 #(.W(REC_W)) u_fifo (
        .clk_in    (clk_in),
        .reset     (reset),
        .push      (ack_ok),
        .push_data (push_rec),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_comb begin
        active  = (state_q == ST_FILL) || (state_q == ST_RUN);
        ack_ok  = gold_ack && req_q && active;
        pop     = (state_q == ST_RUN) && cpu_valid && (fifo_count != 2'd0);
        cause_d = CAUSE_NONE;
        // Underrun is checked first: with an empty FIFO the head is stale.
        if ((state_q == ST_RUN) && cpu_valid && (fifo_count == 2'd0))
            cause_d = CAUSE_UNDERRUN;
        else if (pop && (fifo_head.pc != cpu_pc))
            cause_d = CAUSE_PC;
        else if (pop && (fifo_head.inst != cpu_inst))
            cause_d = CAUSE_INST;
        hit = pop && (cause_d == CAUSE_NONE);

        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_FILL;
            ST_FILL: if (ack_ok) state_d = ST_RUN;
            ST_RUN: begin
                if (cause_d != CAUSE_NONE)
                    state_d = ST_FAIL;
                else if (hit && ((match_q + 1'b1) == LEN))
                    state_d = ST_PASS;
            end
            default: state_d = state_q;
        endcase

        // With no request outstanding, only buffered entries count toward the limit.
        raise = !req_q && ((state_d == ST_FILL) || (state_d == ST_RUN))
                && (fifo_count < 2'd2) && (fetch_q < LEN);
        if (req_q)
            req_d = !ack_ok && ((state_d == ST_FILL) || (state_d == ST_RUN));
        else
            req_d = raise;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= 1'b1;
            req_q   <= 1'b0;
            addr_q  <= '0;
            fetch_q <= '0;
            match_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
            fidx_q  <= '0;
            fpc_q   <= '0;
            finst_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= (state_d == ST_IDLE) || (state_d == ST_FILL);
            req_q   <= req_d;
            if (raise)  addr_q  <= fetch_q[ADDR_W-1:0];
            if (ack_ok) fetch_q <= fetch_q + 1'b1;
            if (hit)    match_q <= match_q + 1'b1;
            if ((state_q == ST_RUN) && (state_d == ST_PASS)) begin
                pass_q <= 1'b1;
                done_q <= 1'b1;
            end
            if ((state_q == ST_RUN) && (cause_d != CAUSE_NONE)) begin
                fail_q  <= 1'b1;
                done_q  <= 1'b1;
                cause_q <= cause_d;
                fidx_q  <= match_q[ADDR_W-1:0];
                fpc_q   <= cpu_pc;
                finst_q <= cpu_inst;
            end
        end
    end

    assign cpu_hold    = hold_q;
    assign gold_req    = req_q;
    assign gold_addr   = addr_q;
    assign chk_done    = done_q;
    assign chk_pass    = pass_q;
    assign chk_fail    = fail_q;
    assign fail_cause  = cause_q;
    assign fail_index  = fidx_q;
    assign fail_pc     = fpc_q;
    assign fail_inst   = finst_q;
    assign match_count = match_q;

endmodule

// File: tb/tb_trace_checker.sv
// Scoreboard bench for trace_checker: a golden-memory responder with variable
// ack latency, a behavioural checker model and one check task for all compares.
module tb_trace_checker;
    import trace_checker_pkg::*;

    localparam int ADDR_W = 10;
    localparam int LEN    = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_valid = 1'b0;
    logic [31:0]       cpu_pc = '0;
    logic [31:0]       cpu_inst = '0;
    logic              cpu_hold;
    logic              gold_req;
    logic [ADDR_W-1:0] gold_addr;
    logic              gold_ack = 1'b0;
    logic [31:0]       gold_pc = '0;
    logic [31:0]       gold_inst = '0;
    logic              chk_done, chk_pass, chk_fail;
    logic [1:0]        fail_cause;
    logic [ADDR_W-1:0] fail_index;
    logic [31:0]       fail_pc, fail_inst;
    logic [ADDR_W:0]   match_count;

    always #5 clk = ~clk;

    trace_checker #(.ADDR_W(ADDR_W), .TRACE_LEN(LEN)) dut (
        .clk_in      (clk),
        .reset       (reset),
        .cpu_valid   (cpu_valid),
        .cpu_pc      (cpu_pc),
        .cpu_inst    (cpu_inst),
        .cpu_hold    (cpu_hold),
        .gold_req    (gold_req),
        .gold_addr   (gold_addr),
        .gold_ack    (gold_ack),
        .gold_pc     (gold_pc),
        .gold_inst   (gold_inst),
        .chk_done    (chk_done),
        .chk_pass    (chk_pass),
        .chk_fail    (chk_fail),
        .fail_cause  (fail_cause),
        .fail_index  (fail_index),
        .fail_pc     (fail_pc),
        .fail_inst   (fail_inst),
        .match_count (match_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        logic        done, pass, fail;
        logic [1:0]  cause;
        logic [31:0] idx, pc, inst, mc;
    } exp_t;

    exp_t   sb[$];
    exp_t   m_v;
    state_e m_state;
    int     m_q[$];
    int     m_match, m_fetch;
    int     lat, wait_cnt;
    int     fault_kind, fault_rec;
    int     overlap;

    function automatic logic [31:0] gpc(input int i);
        return 32'h0040_0000 + 32'(4 * i);
    endfunction

    function automatic logic [31:0] ginst(input int i);
        return 32'h2001_0001 + 32'(i);
    endfunction

    function automatic bit terminal();
        return (m_state == ST_PASS) || (m_state == ST_FAIL);
    endfunction

    task automatic model_reset();
        m_state  = ST_IDLE;
        m_q.delete();
        sb.delete();
        m_match  = 0;
        m_fetch  = 0;
        wait_cnt = 0;
        overlap  = 0;
        m_v      = '{done: 0, pass: 0, fail: 0, cause: 0, idx: 0, pc: 0, inst: 0, mc: 0};
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cpu_valid = 1'b0;
        gold_ack  = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check_eq("rst_hold",  cpu_hold,    1);
        check_eq("rst_req",   gold_req,    0);
        check_eq("rst_addr",  gold_addr,   0);
        check_eq("rst_done",  chk_done,    0);
        check_eq("rst_pass",  chk_pass,    0);
        check_eq("rst_fail",  chk_fail,    0);
        check_eq("rst_cause", fail_cause,  0);
        check_eq("rst_index", fail_index,  0);
        check_eq("rst_fpc",   fail_pc,     0);
        check_eq("rst_finst", fail_inst,   0);
        check_eq("rst_count", match_count, 0);
        reset = 1'b0;
    endtask

    task automatic model_fail(input logic [1:0] cause);
        m_v.done  = 1; m_v.fail = 1; m_v.cause = cause;
        m_v.idx   = 32'(m_match); m_v.pc = cpu_pc; m_v.inst = cpu_inst;
        m_state   = ST_FAIL;
    endtask

    // mode 0: retire when a record is buffered; 1: back-to-back; 2: retire alongside an ack
    task automatic cycle(input int mode);
        bit     req_seen, accepted, v;
        int     rec, h;
        state_e pre;
        exp_t   e;
        req_seen = gold_req;
        gold_ack = 1'b0;
        if (req_seen) begin
            check_eq("gold_addr", gold_addr, m_fetch);
            if (wait_cnt + 1 >= lat) begin
                gold_ack  = 1'b1;
                gold_pc   = gpc(m_fetch);
                gold_inst = ginst(m_fetch);
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end
        pre = m_state;
        if (pre != ST_RUN)  v = 1'b1;
        else if (mode == 1) v = 1'b1;
        else if (mode == 2) v = (m_q.size() > 0) && (gold_ack || m_fetch == LEN);
        else                v = (m_q.size() > 0);
        rec       = m_match;
        cpu_valid = v;
        cpu_pc    = gpc(rec) + ((fault_kind == 1 && rec == fault_rec) ? 32'd8 : 32'd0);
        cpu_inst  = ginst(rec) - ((fault_kind == 2 && rec == fault_rec) ? 32'd1 : 32'd0);

        accepted = gold_ack && req_seen && (pre == ST_FILL || pre == ST_RUN);
        if (pre == ST_RUN && v) begin
            if (accepted && m_q.size() == 1) overlap++;
            if (m_q.size() == 0) model_fail(CAUSE_UNDERRUN);
            else begin
                h = m_q.pop_front();
                if (cpu_pc != gpc(h))          model_fail(CAUSE_PC);
                else if (cpu_inst != ginst(h)) model_fail(CAUSE_INST);
                else begin
                    m_match++;
                    if (m_match == LEN) begin
                        m_v.done = 1; m_v.pass = 1; m_state = ST_PASS;
                    end
                end
            end
        end
        if (accepted) begin
            m_q.push_back(m_fetch);
            m_fetch++;
        end
        if (pre == ST_IDLE) m_state = ST_FILL;
        else if (pre == ST_FILL && accepted) m_state = ST_RUN;
        m_v.mc = 32'(m_match);
        if (v) begin
            e = m_v;
            sb.push_back(e);
        end

        @(posedge clk); #1;
        gold_ack  = 1'b0;
        cpu_valid = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (pre == ST_RUN)
                $display("txn rec=%0d pc=%h inst=%h -> done=%0b pass=%0b cause=%0d count=%0d",
                         rec, cpu_pc, cpu_inst, chk_done, chk_pass, fail_cause, match_count);
            check_eq("chk_done",    chk_done,    e.done);
            check_eq("chk_pass",    chk_pass,    e.pass);
            check_eq("chk_fail",    chk_fail,    e.fail);
            check_eq("fail_cause",  fail_cause,  e.cause);
            check_eq("fail_index",  fail_index,  e.idx);
            check_eq("fail_pc",     fail_pc,     e.pc);
            check_eq("fail_inst",   fail_inst,   e.inst);
            check_eq("match_count", match_count, e.mc);
        end
        check_eq("cpu_hold", cpu_hold, (m_state == ST_IDLE || m_state == ST_FILL));
        if (terminal()) check_eq("req_terminal", gold_req, 0);
    endtask

    task automatic run_to_end(input int mode);
        for (int c = 0; c < 200 && !terminal(); c++) cycle(mode);
        check_eq("verdict_reached", terminal(), 1);
        for (int c = 0; c < 3; c++) cycle(mode);
    endtask

    task automatic run_trace(input int l, input int mode, input int fk, input int fr);
        lat = l; fault_kind = fk; fault_rec = fr;
        do_reset();
        run_to_end(mode);
    endtask

    initial begin
        lat = 1; fault_kind = 0; fault_rec = 0;
        model_reset();

        run_trace(1, 0, 0, 0);
        check_eq("t1_pass",  chk_pass,    1);
        check_eq("t1_count", match_count, 4);

        run_trace(1, 0, 1, 2);
        check_eq("t2_fail",  chk_fail,   1);
        check_eq("t2_cause", fail_cause, 1);
        check_eq("t2_index", fail_index, 2);
        check_eq("t2_pc",    fail_pc,    32'h0040_0010);

        run_trace(1, 0, 2, 1);
        check_eq("t3_cause", fail_cause, 2);
        check_eq("t3_index", fail_index, 1);
        check_eq("t3_inst",  fail_inst,  32'h2001_0001);

        run_trace(5, 1, 0, 0);
        check_eq("t4_fail",  chk_fail,   1);
        check_eq("t4_cause", fail_cause, 3);

        run_trace(1, 2, 0, 0);
        check_eq("t6_overlap", overlap > 0, 1);
        check_eq("t6_pass",    chk_pass,    1);
        check_eq("t6_count",   match_count, 4);

        // Reset in RUN with a request outstanding, then a late ack.
        lat = 3; fault_kind = 0;
        do_reset();
        for (int c = 0; c < 100 && !(m_state == ST_RUN && m_match >= 1 && gold_req); c++) cycle(0);
        check_eq("t5_outstanding", gold_req, 1);
        reset = 1'b1;
        #1;
        check_eq("t5_async_hold",  cpu_hold,    1);
        check_eq("t5_async_req",   gold_req,    0);
        check_eq("t5_async_addr",  gold_addr,   0);
        check_eq("t5_async_done",  chk_done,    0);
        check_eq("t5_async_count", match_count, 0);
        #2;
        reset     = 1'b0;
        gold_ack  = 1'b1;
        gold_pc   = gpc(m_fetch);
        gold_inst = ginst(m_fetch);
        model_reset();
        @(posedge clk); #1;
        gold_ack = 1'b0;
        m_state  = ST_FILL;
        check_eq("t5_hold",  cpu_hold,    1);
        check_eq("t5_count", match_count, 0);
        check_eq("t5_done",  chk_done,    0);
        lat = 1000;
        for (int c = 0; c < 3; c++) cycle(0);
        lat = 1;
        run_to_end(0);
        check_eq("t5_pass", chk_pass, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 SHALL have parameters: ADDR_W, 10, golden index width; TRACE_LEN, 1024, golden records to check (1..2^ADDR_W).
REQ-002 clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 cpu_valid  input  1  one instruction retires this cycle.
REQ-005 cpu_pc  input  32  pc of the retiring instruction.
REQ-006 cpu_inst  input  32  instruction word of the retiring instruction.
REQ-007 cpu_hold  output  1  holds the CPU in reset until the first golden record is buffered.
REQ-008 gold_req  output  1  golden-record read request.
REQ-009 gold_addr  output  ADDR_W  golden record index.
REQ-010 gold_ack  input  1  golden data valid; completes the request.
REQ-011 gold_pc  input  32  expected pc; sampled on gold_ack.
REQ-012 gold_inst  input  32  expected instruction; sampled on gold_ack.
REQ-013 chk_done  output  1  verdict reached (PASS or FAIL).
REQ-014 chk_pass  output  1  all TRACE_LEN records matched.
REQ-015 chk_fail  output  1  first mismatch or underrun detected.
REQ-016 fail_cause  output  2  0 none, 1 pc mismatch, 2 inst mismatch, 3 underrun.
REQ-017 fail_index  output  ADDR_W  index of the failing record.
REQ-018 fail_pc / fail_inst  output  32 each  CPU values captured at failure.
REQ-019 match_count  output  ADDR_W+1  records matched so far.

Function
REQ-020 FSM states: IDLE, FILL, RUN, PASS, FAIL; IDLE->FILL on the first clock after reset deasserts.
REQ-021 FILL->RUN on the edge at which the buffer becomes non-empty; cpu_hold=1 in IDLE and FILL, 0 otherwise.
REQ-022 Golden records are buffered in a 2-entry FIFO; at most one request is outstanding.
REQ-023 gold_req is raised when (fifo count + outstanding) < 2, fetch index < TRACE_LEN, and state is FILL or RUN.
REQ-024 gold_req and gold_addr hold stable until gold_ack; deassert the cycle after ack, then re-raise per REQ-023.
REQ-025 gold_addr increments by 1 per accepted request, from 0 up to TRACE_LEN-1; gold_ack without an outstanding request is ignored.
REQ-026 In RUN, cpu_valid pops the FIFO head and compares it with cpu_pc/cpu_inst in the same cycle.
REQ-027 Compare priority: pc mismatch (cause 1) before inst mismatch (cause 2).
REQ-028 cpu_valid with an empty FIFO in RUN gives cause 3 (underrun).
REQ-029 Verdict outputs register 1 cycle after the deciding cpu_valid edge.
REQ-030 On a match, match_count increments; when it reaches TRACE_LEN, next state is PASS.
REQ-031 On any failure, next state is FAIL; fail_index, fail_pc and fail_inst are captured on that edge.
REQ-032 PASS and FAIL are terminal and sticky until reset; cpu_valid and gold_ack are ignored there, and gold_req=0.
REQ-033 Simultaneous gold_ack and pop: push and pop both take effect; count is unchanged and the ordering is preserved.
REQ-034 chk_done = chk_pass | chk_fail; chk_pass and chk_fail are never both 1.
REQ-035 cpu_valid in IDLE or FILL is ignored.

Reset
REQ-036 Reset values: state IDLE, FIFO empty, no request outstanding, fetch index 0, gold_req=0, gold_addr=0, cpu_hold=1.
REQ-037 Reset values: all verdict outputs, fail_* and match_count are 0.
REQ-038 Reset asserted mid-operation aborts any outstanding request; a late gold_ack after reset is ignored.

Structure
REQ-039 A shared package holds the FSM state encodings and the fail_cause codes (CAUSE_NONE/PC/INST/UNDERRUN).
REQ-040 The 2-entry FIFO is the sub-module trace_fifo2: 64-bit data, push, pop, count, asynchronous active-high reset.

Verification
REQ-041 TRACE_LEN=4, golden pc 0x00400000..0x0040000C, ack latency 1, four matching retires -> chk_pass=1, match_count=4.
REQ-042 Record 2 has cpu_pc=0x00400010 vs golden 0x00400008 -> chk_fail=1, cause=1, fail_index=2, fail_pc=0x00400010.
REQ-043 Record 1 has pc correct, cpu_inst=0x20010001 vs golden 0x20010002 -> cause=2, fail_index=1, fail_inst=0x20010001.
REQ-044 gold_ack latency 5 cycles, back-to-back cpu_valid -> cause=3 at the first empty pop; gold_addr holds stable while waiting.
REQ-045 Assert reset during RUN with a request outstanding, then ack the next cycle -> all outputs return to reset values, cpu_hold=1, FIFO stays empty.
REQ-046 Simultaneous ack and pop with 1 entry buffered -> records checked in order, count stays 1, chk_pass at TRACE_LEN.
